// File: rtl/strobe_phase_gen.sv
// Multi-channel strobe generator with a shared modulo counter.
// Period/phase updates are handshaked in and applied on a period wrap.
module strobe_phase_gen #(
  parameter int unsigned PER_W   = 20,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PER_DEF = 20,
  parameter int unsigned PH_DEF  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    cfg_vld_i,
  output logic                    cfg_rdy_o,
  input  logic [PER_W-1:0]        cfg_per_i,
  input  logic [NUM_CH*PER_W-1:0] cfg_ph_i,
  output logic [NUM_CH-1:0]       stb_o,
  output logic                    wrap_o,
  output logic                    cfg_done_o,
  output logic                    cfg_err_o
);

  typedef enum logic {
    IDLE,
    PEND
  } state_e;

  typedef logic [NUM_CH-1:0][PER_W-1:0] ph_arr_t;

  localparam logic [PER_W-1:0] ONE     = PER_W'(1);
  localparam logic [PER_W-1:0] PER_RST = PER_W'(PER_DEF);
  localparam logic [PER_W-1:0] PH_RST  = PER_W'(PH_DEF);

  state_e              state_q, state_d;
  logic [PER_W-1:0]    cnt_q, cnt_d;
  logic [PER_W-1:0]    per_q, per_d;
  ph_arr_t             ph_q, ph_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic [PER_W-1:0]    sh_per_q, sh_per_d;
  ph_arr_t             sh_ph_q, sh_ph_d;
  logic [NUM_CH-1:0]   stb_q, stb_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                last;
  logic                hit;
  logic [PER_W-1:0]    new_per;
  logic [NUM_CH-1:0]   new_en;

  // Wrap detection against the active period
  always_comb begin
    last = (cnt_q == per_q - ONE);
    hit  = en_i & last;
  end

  // Shadow period clamp and per-channel validity of shadow phases
  always_comb begin
    new_per = (sh_per_q == '0) ? ONE : sh_per_q;
    new_en  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      new_en[k] = (sh_ph_q[k] < new_per);
    end
  end

  // Shared modulo counter, advances only on enabled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = last ? '0 : cnt_q + ONE;
    end
  end

  // Registered strobe and wrap pulses from current settings
  always_comb begin
    stb_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      stb_d[k] = en_i & ch_en_q[k] & (cnt_q == ph_q[k]);
    end
    wrap_d = hit;
  end

  // Config FSM: capture request, then commit on the next wrap
  always_comb begin
    state_d  = state_q;
    sh_per_d = sh_per_q;
    sh_ph_d  = sh_ph_q;
    per_d    = per_q;
    ph_d     = ph_q;
    ch_en_d  = ch_en_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_vld_i) begin
          sh_per_d = cfg_per_i;
          sh_ph_d  = cfg_ph_i;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (hit) begin
          per_d   = new_per;
          ph_d    = sh_ph_q;
          ch_en_d = new_en;
          done_d  = 1'b1;
          err_d   = ~&new_en;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, counter and active settings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= PER_RST;
      ph_q    <= {NUM_CH{PH_RST}};
      ch_en_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ph_q    <= ph_d;
      ch_en_q <= ch_en_d;
    end
  end

  // Shadow registers for a pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_per_q <= '0;
      sh_ph_q  <= '0;
    end else begin
      sh_per_q <= sh_per_d;
      sh_ph_q  <= sh_ph_d;
    end
  end

  // Output pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      stb_q  <= stb_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign cfg_rdy_o  = (state_q == IDLE);
  assign stb_o      = stb_q;
  assign wrap_o     = wrap_q;
  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_strobe_phase_gen.sv
// Directed bench for strobe_phase_gen.
// Table vectors plus hand-built config sequences.
module tb_strobe_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic        cfg_vld_i;
  logic        cfg_rdy_o;
  logic [19:0] cfg_per_i;
  logic [79:0] cfg_ph_i;
  logic [3:0]  stb_o;
  logic        wrap_o;
  logic        cfg_done_o;
  logic        cfg_err_o;

  int checks;
  int failures;

  typedef struct {
    logic        en;
    logic        vld;
    logic [19:0] per;
    logic [79:0] ph;
    logic [3:0]  stb;
    logic        wrap;
    logic        done;
    logic        err;
    logic        rdy;
  } vec_t;

  vec_t tv[16];

  strobe_phase_gen #(
    .PER_W(20),
    .NUM_CH(4),
    .PER_DEF(20),
    .PH_DEF(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .cfg_vld_i(cfg_vld_i),
    .cfg_rdy_o(cfg_rdy_o),
    .cfg_per_i(cfg_per_i),
    .cfg_ph_i(cfg_ph_i),
    .stb_o(stb_o),
    .wrap_o(wrap_o),
    .cfg_done_o(cfg_done_o),
    .cfg_err_o(cfg_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] pk(
    input logic [19:0] p0, input logic [19:0] p1,
    input logic [19:0] p2, input logic [19:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [3:0] estb(
    input logic [79:0] ph, input logic [3:0] msk, input int c);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k] = msk[k] && (ph[k*20 +: 20] == 20'(c));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic outs(input string nm, input logic [3:0] s,
                      input logic w, input logic d,
                      input logic e, input logic r);
    chk({nm, ".stb"}, 32'(stb_o), 32'(s));
    chk({nm, ".wrap"}, 32'(wrap_o), 32'(w));
    chk({nm, ".done"}, 32'(cfg_done_o), 32'(d));
    chk({nm, ".err"}, 32'(cfg_err_o), 32'(e));
    chk({nm, ".rdy"}, 32'(cfg_rdy_o), 32'(r));
  endtask

  task automatic step(input logic e, input logic v,
                      input logic [19:0] p, input logic [79:0] ph);
    en_i      = e;
    cfg_vld_i = v;
    cfg_per_i = p;
    cfg_ph_i  = ph;
    @(posedge clk);
    @(negedge clk);
    cfg_vld_i = 1'b0;
  endtask

  task automatic run_chk(input string nm, input int n, input int per,
                         input int c0, input logic [79:0] ph,
                         input logic [3:0] msk, input logic r);
    int c;
    for (int i = 0; i < n; i++) begin
      c = (c0 + i) % per;
      step(1'b1, 1'b0, 20'd0, 80'd0);
      outs($sformatf("%s[%0d]", nm, i), estb(ph, msk, c),
           c == per - 1, 1'b0, 1'b0, r);
    end
  endtask

  logic [79:0] p0, p2, p3, p4, p4b, p5;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    en_i      = 1'b0;
    cfg_vld_i = 1'b0;
    cfg_per_i = '0;
    cfg_ph_i  = '0;
    p0  = pk(0, 0, 0, 0);
    p2  = pk(0, 5, 10, 19);
    p3  = pk(0, 1, 2, 7);
    p4  = pk(0, 1, 3, 6);
    p4b = pk(0, 1, 3, 2);
    p5  = pk(0, 1, 2, 2);

    tv[0]  = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 1'b1, 20'd3, p5,    4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[13] = '{1'b1, 1'b0, 20'd0, 80'd0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[14] = '{1'b0, 1'b0, 20'd0, 80'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[15] = '{1'b1, 1'b0, 20'd0, 80'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    outs("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // T1 defaults
    run_chk("t1", 60, 20, 0, p0, 4'hF, 1'b1);

    // T2 same period, new phases, requested mid-period
    run_chk("t2pre", 7, 20, 0, p0, 4'hF, 1'b1);
    step(1'b1, 1'b1, 20'd20, p2);
    outs("t2acc", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_chk("t2pend", 11, 20, 8, p0, 4'hF, 1'b0);
    step(1'b1, 1'b0, 20'd0, 80'd0);
    outs("t2commit", 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_chk("t2new", 20, 20, 0, p2, 4'hF, 1'b1);

    // T3 shrink period 20 -> 8
    run_chk("t3pre", 3, 20, 0, p2, 4'hF, 1'b1);
    step(1'b1, 1'b1, 20'd8, p3);
    outs("t3acc", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_chk("t3pend", 15, 20, 4, p2, 4'hF, 1'b0);
    step(1'b1, 1'b0, 20'd0, 80'd0);
    outs("t3commit", 4'h8, 1'b1, 1'b1, 1'b0, 1'b1);
    run_chk("t3new", 24, 8, 0, p3, 4'hF, 1'b1);

    // T4 out-of-range phase disables ch3, then re-enable
    step(1'b1, 1'b1, 20'd4, p4);
    outs("t4acc", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_chk("t4pend", 6, 8, 1, p3, 4'hF, 1'b0);
    step(1'b1, 1'b0, 20'd0, 80'd0);
    outs("t4commit", 4'h8, 1'b1, 1'b1, 1'b1, 1'b1);
    run_chk("t4dis", 12, 4, 0, p4, 4'h7, 1'b1);
    step(1'b1, 1'b1, 20'd4, p4b);
    outs("t4racc", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_chk("t4rpend", 2, 4, 1, p4, 4'h7, 1'b0);
    step(1'b1, 1'b0, 20'd0, 80'd0);
    outs("t4rcommit", 4'h4, 1'b1, 1'b1, 1'b0, 1'b1);
    run_chk("t4ren", 8, 4, 0, p4b, 4'hF, 1'b1);

    // T5 en_i toggling with a pending request held across idle cycles
    for (int i = 0; i < 16; i++) begin
      step(tv[i].en, tv[i].vld, tv[i].per, tv[i].ph);
      outs($sformatf("t5[%0d]", i), tv[i].stb, tv[i].wrap,
           tv[i].done, tv[i].err, tv[i].rdy);
    end

    // Period 0 request clamps to 1
    step(1'b1, 1'b1, 20'd0, p0);
    outs("p1acc", 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 20'd0, 80'd0);
    outs("p1commit", 4'hC, 1'b1, 1'b1, 1'b0, 1'b1);
    run_chk("p1run", 4, 1, 0, p0, 4'hF, 1'b1);

    // T6 reset during PEND
    step(1'b1, 1'b1, 20'd8, pk(0, 1, 2, 3));
    outs("t6acc", 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    outs("t6rst", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk("t6post", 40, 20, 0, p0, 4'hF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
